// File: rtl/screen_writer_if.sv
// Screen writer port bundle: CPU write side, fill control, and the RAM write port.
// Latency: none, wires only.
// Backpressure: cpu_ready travels back to the CPU alongside the write request.
interface screen_writer_if;
    logic [14:0] cpu_address;
    logic [15:0] cpu_data;
    logic        cpu_write;
    logic        cpu_ready;
    logic        fill_req;
    logic [15:0] fill_value;
    logic [12:0] write_address;
    logic [15:0] data_in;
    logic        load;
    logic        busy;
    logic        fill_done;

    // CPU / controller side
    modport master (
        output cpu_address, cpu_data, cpu_write, fill_req, fill_value,
        input  cpu_ready, write_address, data_in, load, busy, fill_done
    );

    // screen writer side
    modport slave (
        input  cpu_address, cpu_data, cpu_write, fill_req, fill_value,
        output cpu_ready, write_address, data_in, load, busy, fill_done
    );
endinterface

// File: rtl/screen_writer.sv
// Screen RAM write front end: queues in-window CPU writes and runs a full-screen fill engine.
// Latency: CPU write accepted at edge N appears on load/write_address/data_in after edge N+1 when idle.
// Backpressure: cpu_ready drops while the write queue is full; fill stalls draining, never CPU enqueue.
module screen_writer #(
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [14:0] SCREEN_BASE  = 15'h4000,
    parameter int          SCREEN_WORDS = 8192
) (
    input  logic            clk,
    input  logic            reset_n,
    screen_writer_if.slave  bus
);

    localparam int PW = $clog2(FIFO_DEPTH) + 1;
    localparam int IW = PW - 1;

    localparam logic [15:0] BASE_EXT = {1'b0, SCREEN_BASE};
    localparam logic [15:0] END_EXT  = BASE_EXT + 16'(SCREEN_WORDS);
    localparam logic [12:0] LAST_IDX = 13'(SCREEN_WORDS - 1);

    typedef enum logic {IDLE, FILL} state_t;

    typedef struct packed {
        logic [12:0] addr;
        logic [15:0] dat;
    } wr_ent_t;

    state_t        state, state_nxt;
    wr_ent_t       fifo_mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic          fifo_empty, fifo_full;
    logic          in_window, push, pop;
    logic          fill_start, fill_end, fill_end_q;
    logic [12:0]   fill_cnt;
    logic [15:0]   fill_val;
    wr_ent_t       push_ent, rd_ent;
    logic [15:0]   addr_ext;

    assign addr_ext   = {1'b0, bus.cpu_address};
    assign in_window  = (addr_ext >= BASE_EXT) && (addr_ext < END_EXT);
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]) && (wr_ptr[PW-1] != rd_ptr[PW-1]);
    // Readiness is taken before any same-cycle pop: a full queue never bypasses.
    assign push       = bus.cpu_write && in_window && !fifo_full;
    assign push_ent   = '{addr: 13'(bus.cpu_address - SCREEN_BASE), dat: bus.cpu_data};
    assign rd_ent     = fifo_mem[rd_ptr[IW-1:0]];

    assign bus.cpu_ready = !fifo_full;
    assign bus.busy      = (state == FILL) || !fifo_empty;

    // Next state and per-cycle control: fill request wins the cycle, otherwise drain one entry.
    always_comb begin
        state_nxt  = state;
        fill_start = 1'b0;
        fill_end   = 1'b0;
        pop        = 1'b0;
        case (state)
            IDLE: begin
                if (bus.fill_req) begin
                    fill_start = 1'b1;
                    state_nxt  = FILL;
                end else begin
                    pop = !fifo_empty;
                end
            end
            FILL: begin
                if (fill_cnt == LAST_IDX) begin
                    fill_end  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_nxt;
    end

    // Queue storage; contents are don't-care until the write pointer covers them.
    always_ff @(posedge clk) begin
        if (push) fifo_mem[wr_ptr[IW-1:0]] <= push_ent;
    end

    // Queue pointers; reset empties the queue and drops pending writes.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Registered RAM write port, fill counter and the done pulse one cycle after the last fill word.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bus.load          <= 1'b0;
            bus.write_address <= '0;
            bus.data_in       <= '0;
            bus.fill_done     <= 1'b0;
            fill_end_q        <= 1'b0;
            fill_cnt          <= '0;
            fill_val          <= '0;
        end else begin
            bus.load      <= 1'b0;
            fill_end_q    <= fill_end;
            bus.fill_done <= fill_end_q;
            if (fill_start) begin
                fill_val <= bus.fill_value;
                fill_cnt <= '0;
            end
            if (state == FILL) begin
                bus.load          <= 1'b1;
                bus.write_address <= fill_cnt;
                bus.data_in       <= fill_val;
                fill_cnt          <= fill_cnt + 13'd1;
            end else if (pop) begin
                bus.load          <= 1'b1;
                bus.write_address <= rd_ent.addr;
                bus.data_in       <= rd_ent.dat;
            end
        end
    end

endmodule

// File: tb/tb_screen_writer.sv
// Bench for screen_writer: directed writes and fills, scoreboard of expected RAM writes.
// Latency: expected entries are queued at acceptance, the monitor pops them on each load.
// Backpressure: the CPU driver holds a write until cpu_ready was seen high.
module tb_screen_writer;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    screen_writer_if bus ();

    screen_writer #(
        .FIFO_DEPTH   (4),
        .SCREEN_BASE  (15'h4000),
        .SCREEN_WORDS (8192)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic        last;
        logic [12:0] addr;
        logic [15:0] dat;
    } exp_t;

    exp_t        exp_q [$];
    exp_t        mon_e;
    int          vectors     = 0;
    int          miscompares = 0;
    int          done_cnt    = 0;
    logic        exp_done    = 1'b0;
    logic [15:0] ram [8192];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every load must match the head of the expected queue; fill_done must follow the last fill word.
    always @(negedge clk) begin
        if (reset_n) begin
            if (bus.fill_done || exp_done) check("fill_done_pulse", 32'(bus.fill_done), 32'(exp_done));
            if (bus.fill_done) done_cnt++;
            exp_done = 1'b0;
            if (bus.load) begin
                ram[bus.write_address] = bus.data_in;
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_load: got addr 0x%0h data 0x%0h, expected no load at %0t",
                             bus.write_address, bus.data_in, $time);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("load_addr", 32'(bus.write_address), 32'(mon_e.addr));
                    check("load_data", 32'(bus.data_in), 32'(mon_e.dat));
                    exp_done = mon_e.last;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cpu_wr(input logic [14:0] a, input logic [15:0] d);
        logic r;
        int   n;
        n = 0;
        bus.cpu_address = a;
        bus.cpu_data    = d;
        bus.cpu_write   = 1'b1;
        do begin
            @(negedge clk);
            r = bus.cpu_ready;
            tick();
            n++;
        end while (!r && n < 10000);
        bus.cpu_write = 1'b0;
        if (!r) begin
            vectors++;
            miscompares++;
            $display("FAIL cpu_wr_timeout: got cpu_ready 0 for %0d cycles, expected acceptance", n);
        end else if (a >= 15'h4000 && a < 15'h6000) begin
            exp_q.push_back('{last: 1'b0, addr: 13'(a - 15'h4000), dat: d});
        end
    endtask

    task automatic push_fill(input logic [15:0] v);
        for (int i = 0; i < 8192; i++)
            exp_q.push_back('{last: (i == 8191), addr: 13'(i), dat: v});
    endtask

    task automatic start_fill(input logic [15:0] v);
        bus.fill_req   = 1'b1;
        bus.fill_value = v;
        push_fill(v);
        tick();
        bus.fill_req = 1'b0;
    endtask

    task automatic wait_done(input int snap);
        int n;
        n = 0;
        while (done_cnt == snap && n < 9000) begin
            @(negedge clk);
            n++;
        end
        if (done_cnt == snap) begin
            vectors++;
            miscompares++;
            $display("FAIL fill_done_timeout: got no fill_done in %0d cycles, expected one", n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout: got no end of run, expected finish");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares + 1);
        $fatal(1);
    end

    initial begin
        int snap;
        int n;

        reset_n         = 1'b0;
        bus.cpu_address = '0;
        bus.cpu_data    = '0;
        bus.cpu_write   = 1'b0;
        bus.fill_req    = 1'b0;
        bus.fill_value  = '0;
        #12;
        check("rst_load",      32'(bus.load),          32'd0);
        check("rst_addr",      32'(bus.write_address), 32'd0);
        check("rst_data",      32'(bus.data_in),       32'd0);
        check("rst_busy",      32'(bus.busy),          32'd0);
        check("rst_fill_done", 32'(bus.fill_done),     32'd0);
        check("rst_cpu_ready", 32'(bus.cpu_ready),     32'd1);
        @(negedge clk);
        reset_n = 1'b1;
        tick();

        // Single writes at both ends of the window
        cpu_wr(15'h4000, 16'hAAAA);
        @(negedge clk);
        check("t1_busy_queued", 32'(bus.busy), 32'd1);
        check("t1_load_not_yet", 32'(bus.load), 32'd0);
        @(negedge clk);
        check("t1_load_high", 32'(bus.load), 32'd1);
        @(negedge clk);
        check("t1_load_low", 32'(bus.load), 32'd0);
        tick();
        cpu_wr(15'h5FFF, 16'h0001);
        repeat (3) tick();

        // Just outside the window on both sides
        bus.cpu_address = 15'h3FFF;
        bus.cpu_data    = 16'h1111;
        bus.cpu_write   = 1'b1;
        @(negedge clk);
        check("t2_ready_below", 32'(bus.cpu_ready), 32'd1);
        tick();
        bus.cpu_address = 15'h6000;
        bus.cpu_data    = 16'h2222;
        @(negedge clk);
        check("t2_ready_above", 32'(bus.cpu_ready), 32'd1);
        tick();
        bus.cpu_write = 1'b0;
        repeat (3) begin
            @(negedge clk);
            check("t2_busy_idle", 32'(bus.busy), 32'd0);
        end
        tick();

        // Full fill with all ones
        snap = done_cnt;
        start_fill(16'hFFFF);
        wait_done(snap);
        check("t3_busy_after", 32'(bus.busy), 32'd0);
        tick();

        // CPU writes during a fill: four fit, the fifth stalls until drain resumes
        snap = done_cnt;
        start_fill(16'h0F0F);
        for (int i = 0; i < 4; i++) cpu_wr(15'h4010 + 15'(i), 16'hC000 + 16'(i));
        @(negedge clk);
        check("t4_ready_full", 32'(bus.cpu_ready), 32'd0);
        check("t4_busy_fill", 32'(bus.busy), 32'd1);
        tick();
        cpu_wr(15'h4014, 16'hC004);
        wait_done(snap);
        repeat (8) tick();
        check("t4_drained", 32'(exp_q.size()), 32'd0);

        // Fill request and CPU write in the same cycle: write lands after the fill
        snap = done_cnt;
        bus.cpu_address = 15'h4000;
        bus.cpu_data    = 16'h1234;
        bus.cpu_write   = 1'b1;
        bus.fill_req    = 1'b1;
        bus.fill_value  = 16'h0000;
        push_fill(16'h0000);
        tick();
        bus.cpu_write = 1'b0;
        bus.fill_req  = 1'b0;
        exp_q.push_back('{last: 1'b0, addr: 13'd0, dat: 16'h1234});
        wait_done(snap);
        repeat (4) tick();
        check("t5_ram0", 32'(ram[0]), 32'h1234);
        check("t5_drained", 32'(exp_q.size()), 32'd0);

        // Reset in the middle of a fill with a queued write pending
        start_fill(16'h7777);
        cpu_wr(15'h4020, 16'hBEEF);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(bus.load && bus.write_address == 13'd100) && n < 9000);
        check("t6_reached_word100", 32'(bus.write_address), 32'd100);
        #1;
        reset_n = 1'b0;
        #1;
        check("t6_rst_load",  32'(bus.load),      32'd0);
        check("t6_rst_busy",  32'(bus.busy),      32'd0);
        check("t6_rst_ready", 32'(bus.cpu_ready), 32'd1);
        check("t6_rst_done",  32'(bus.fill_done), 32'd0);
        exp_q.delete();
        exp_done = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        tick();
        snap = done_cnt;
        start_fill(16'h5A5A);
        wait_done(snap);
        repeat (4) tick();
        check("t6_ram_word100", 32'(ram[100]),  32'h5A5A);
        check("t6_ram_word32",  32'(ram[32]),   32'h5A5A);
        check("t6_ram_last",    32'(ram[8191]), 32'h5A5A);
        check("t6_drained",     32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
